// File: rtl/psum_collector_pkg.sv
// Shared constants and helpers for the systolic array's output-side collector
// and the activation feeder that shares its pointer sizing.
package psum_collector_pkg;
  localparam int DATA_WIDTH = 20;
  localparam int SUM_W      = 2 * DATA_WIDTH;
  localparam int COLS_DEF   = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;

  function automatic int col_lsb(input int col, input int lane_w);
    return col * lane_w;
  endfunction
endpackage

// File: rtl/psum_collector_sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is accepted
// only when a pop frees the head slot in the same cycle.
module sync_fifo
  import psum_collector_pkg::*;
#(
  parameter int WIDTH = 2 * SUM_W,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int P_W = $clog2(DEPTH);
  localparam int C_W = P_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [P_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [C_W-1:0]   count_q, count_d;
  logic             push_en, pop_en;

  assign full_o  = (count_q == C_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    pop_en   = pop_i & ~empty_o;
    push_en  = push_i & (~full_o | pop_en);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_en) begin
      wr_ptr_d = wr_ptr_q + P_W'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + P_W'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + C_W'(1'b1);
      2'b01:   count_d = count_q - C_W'(1'b1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end
endmodule

// File: rtl/psum_collector.sv
// Re-aligns the diagonally skewed bottom-row partial sums into one vector per
// activation and queues them on a valid/ready stream, flagging any drop.
module psum_collector
  import psum_collector_pkg::*;
#(
  parameter int data_width         = DATA_WIDTH,
  parameter int w_tile_column_size = COLS_DEF,
  parameter int fifo_depth         = FIFO_DEPTH
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          col0_valid,
  input  logic [2*data_width*w_tile_column_size-1:0]    in_sum,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [2*data_width*w_tile_column_size-1:0]    out_vec,
  output logic [$clog2(fifo_depth):0]                   fifo_count,
  output logic                                          overflow
);
  localparam int LANE_W = 2 * data_width;
  localparam int COLS   = w_tile_column_size;
  localparam int VEC_W  = LANE_W * COLS;

  logic [VEC_W-1:0] aligned_vec;
  logic             aligned_valid;
  logic             fifo_full, fifo_empty, pop;
  logic             overflow_q, overflow_d;

  // Column c arrives c cycles after column 0, so it waits COLS-1-c cycles.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int DLY = COLS - 1 - c;
    localparam int LSB = col_lsb(c, LANE_W);
    if (DLY == 0) begin : g_direct
      assign aligned_vec[LSB +: LANE_W] = in_sum[LSB +: LANE_W];
    end else begin : g_delay
      logic [LANE_W-1:0] dl_q [DLY];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DLY; i++) dl_q[i] <= '0;
        end else begin
          dl_q[0] <= in_sum[LSB +: LANE_W];
          for (int i = 1; i < DLY; i++) dl_q[i] <= dl_q[i-1];
        end
      end
      assign aligned_vec[LSB +: LANE_W] = dl_q[DLY-1];
    end
  end

  if (COLS == 1) begin : g_vld_direct
    assign aligned_valid = col0_valid;
  end else begin : g_vld_shift
    logic [COLS-2:0] vsr_q;
    logic [COLS-1:0] vsr_d;
    assign vsr_d         = {vsr_q, col0_valid};
    assign aligned_valid = vsr_q[COLS-2];
    always_ff @(posedge clk) begin
      if (rst) begin
        vsr_q <= '0;
      end else begin
        vsr_q <= vsr_d[COLS-2:0];
      end
    end
  end

  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign overflow  = overflow_q;

  sync_fifo #(
    .WIDTH (VEC_W),
    .DEPTH (fifo_depth)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (aligned_valid),
    .pop_i   (pop),
    .data_i  (aligned_vec),
    .data_o  (out_vec),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    overflow_d = overflow_q | (aligned_valid & fifo_full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end
endmodule

// File: tb/tb_psum_collector.sv
// Randomized and directed bench for psum_collector against a vector-level
// queue model of the collector's observable behaviour.
module tb_psum_collector;
  localparam int LW    = 40;
  localparam int VW    = 80;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          col0_valid;
  logic [VW-1:0] in_sum;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_vec;
  logic [2:0]    fifo_count;
  logic          overflow;

  psum_collector #(
    .data_width         (20),
    .w_tile_column_size (2),
    .fifo_depth         (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .col0_valid (col0_valid),
    .in_sum     (in_sum),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_vec    (out_vec),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [VW-1:0] exp_q [$];
  bit            ovf_m;
  bit            prev_launch;
  logic [VW-1:0] prev_vec;
  int            launched;

  task automatic check_val(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [VW-1:0] rand_vec();
    return VW'({$urandom(), $urandom(), $urandom()});
  endfunction

  // Called at a falling edge: check outputs, drive one cycle, advance the model.
  task automatic step(input bit launch, input logic [VW-1:0] vec, input bit ready);
    logic [LW-1:0] lane0, lane1;
    logic [VW-1:0] junk;
    int            sz;
    bit            pop;
    check_val("out_valid", VW'(out_valid), VW'(exp_q.size() != 0));
    check_val("fifo_count", VW'(fifo_count), VW'(exp_q.size()));
    check_val("overflow", VW'(overflow), VW'(ovf_m));
    if (exp_q.size() != 0) check_val("out_vec", out_vec, exp_q[0]);
    junk  = rand_vec();
    lane0 = launch ? vec[LW-1:0] : junk[LW-1:0];
    lane1 = prev_launch ? prev_vec[VW-1:LW] : junk[VW-1:LW];
    col0_valid = launch;
    in_sum     = {lane1, lane0};
    out_ready  = ready;
    sz  = exp_q.size();
    pop = (sz != 0) && ready;
    if (pop) void'(exp_q.pop_front());
    if (prev_launch) begin
      if (sz < DEPTH || pop) exp_q.push_back(prev_vec);
      else ovf_m = 1'b1;
    end
    if (launch) launched++;
    prev_launch = launch;
    prev_vec    = vec;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    col0_valid = 1'b0;
    out_ready  = 1'b0;
    in_sum     = rand_vec();
    @(posedge clk);
    exp_q.delete();
    ovf_m       = 1'b0;
    prev_launch = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    prev_vec = '0;
    launched = 0;
    @(negedge clk);
    do_reset();
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);

    // Single vector: two-cycle latency and lane placement.
    step(1'b1, 80'h0000000002_0000000001, 1'b0);
    step(1'b0, '0, 1'b0);
    check_val("latency_valid", VW'(out_valid), 80'd1);
    check_val("latency_vec", out_vec, 80'h0000000002_0000000001);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);

    // Fill to full, then a fifth vector with no pop is dropped.
    for (int i = 0; i < 4; i++) step(1'b1, rand_vec(), 1'b0);
    step(1'b0, '0, 1'b0);
    check_val("full_count", VW'(fifo_count), 80'd4);
    step(1'b1, rand_vec(), 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    check_val("overflow_set", VW'(overflow), 80'd1);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);
    check_val("overflow_sticky", VW'(overflow), 80'd1);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, rand_vec(), 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b1, rand_vec(), 1'b0);
    step(1'b0, '0, 1'b1);
    check_val("pushpop_count", VW'(fifo_count), 80'd4);
    check_val("pushpop_ovf", VW'(overflow), 80'd0);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);

    // Reset one cycle after a launch discards the in-flight vector.
    step(1'b1, rand_vec(), 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);

    // Randomized skewed stream with random back-pressure.
    do_reset();
    launched = 0;
    while (launched < 1000) begin
      step($urandom_range(0, 2) == 0, rand_vec(), $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
    check_val("drained", VW'(fifo_count), 80'd0);
    check_val("random_no_ovf", VW'(overflow), VW'(ovf_m));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/psum_collector.md
# psum_collector

Output-side reader for the systolic PE array: it captures the diagonally skewed partial sums leaving the bottom PE row's `out_sum` bus and re-aligns them into one vector per input activation. Each aligned vector is buffered in a small FIFO and presented on a valid/ready stream to the downstream accumulator/writeback logic. The array cannot stall, so the collector absorbs bursts in its FIFO and flags any loss instead of back-pressuring.

## Interface
- `data_width`, 20, PE operand width; each sum lane is `2*data_width` bits.
- `w_tile_column_size`, 2, number of array columns (COLS); must be ≥1.
- `fifo_depth`, 4, output FIFO entries; must be a power of two, ≥2.

Ports:
- `clk`  in  1  single clock; every register is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `col0_valid`  in  1  column 0 of `in_sum` carries a result this cycle; column c carries the same vector's result c cycles later.
- `in_sum`  in  `2*data_width*COLS`  bottom-row `out_sum`; column c occupies bits `[(c+1)*2*data_width-1 : c*2*data_width]`.
- `out_valid`  out  1  head FIFO entry is available.
- `out_ready`  in  1  downstream accepts the head entry.
- `out_vec`  out  `2*data_width*COLS`  aligned vector, column 0 in the LSBs.
- `fifo_count`  out  `$clog2(fifo_depth)+1`  current FIFO occupancy.
- `overflow`  out  1  sticky flag: a vector was dropped.

## Operation
- Deskew: the column c lane passes through a (COLS-1-c)-stage register delay line, so column COLS-1 is used directly. A COLS-1-stage shift register carries `col0_valid`, giving `aligned_valid`.
- Once the last column is sampled, all lanes are aligned, and `aligned_valid` requests a push of the concatenated vector.
- Push is accepted when `fifo_count < fifo_depth`, or when the FIFO is full and a pop happens in the same cycle.
- Pop happens when `out_valid && out_ready`.
- A push and a pop in the same cycle leave `fifo_count` unchanged.
- Overflow: a push while full with no pop drops the vector. `overflow` is set and stays set until `rst`, and FIFO contents are untouched.
- Back-to-back `col0_valid` pulses (one vector per cycle) are supported at full rate.
- Pointers are `$clog2(fifo_depth)` bits wide and wrap naturally.
- Data passes through unmodified; there is no arithmetic.
- `out_vec` is driven combinationally from the head entry and is don't-care while `out_valid=0`.

## Timing
- Reset values: `out_valid=0`, `fifo_count=0`, `overflow=0`. Pointers, the valid shift register and the delay lines are cleared.
- `rst` asserted mid-operation clears everything in the same edge. Vectors in flight in the deskew stage are discarded.
- For a `col0_valid` pulse in cycle T:
  - column c is sampled in cycle T+c;
  - the FIFO write happens at the end of cycle T+COLS-1;
  - `out_valid` is high from cycle T+COLS when the FIFO was empty.
- Latency with COLS=2 is 2 cycles from `col0_valid` to `out_valid`.
- `out_valid` depends only on registered state; there is no combinational path from `out_ready`.
- `fifo_count` and `overflow` are registered and reflect the edge just past.

## Structure
- Shared package:
  - lane width constant `SUM_W = 2*data_width`;
  - a helper function for the column slice index;
  - the `$clog2`-based pointer-width localparams, reused by the array's activation feeder.
- One sub-module is natural: `sync_fifo` (parameters width and depth; ports `clk`, `rst`, push, pop, `full`, `empty`, `count`).
- The deskew delay lines and the valid shift register stay in the top level as a generate loop over columns.

## Test plan
- COLS=2, one `col0_valid` at cycle 5 with `in_sum` col0=40'h1 in cycle 5 and col1=40'h2 in cycle 6 -> `out_valid` rises in cycle 7 with `out_vec`=80'h0000000002_0000000001.
- Four back-to-back vectors with `out_ready=0` -> `fifo_count` steps 1..4 and `overflow` stays 0. Then raise `out_ready` -> vectors drain in order, one per cycle.
- FIFO full and a fifth vector arrives with `out_ready=0` -> the vector is dropped, `overflow`=1 and sticky, and `fifo_count` stays 4.
- FIFO full with a push and `out_ready=1` in the same cycle -> no overflow, `fifo_count` stays 4, and the new vector is last in drain order.
- `rst` pulsed one cycle after a `col0_valid` -> no vector ever appears, and all outputs return to their reset values.
- Randomized skewed stream with random `out_ready` over 1000 vectors -> the output sequence matches a scoreboard exactly, with no overflow while the average `out_ready` duty is ≥50% and bursts are ≤4.
